// File: rtl/t07_mmio_pkg.sv
// t07_mmio_pkg: shared types and constants for the MMIO-to-Wishbone adapter.
//   rwi_t        request type from the memory handler
//   size_t       access size
//   mmio_state_t adapter FSM states
//   ERR_RDATA_DEF default read data returned on a failed access
package t07_mmio_pkg;
  typedef enum logic [1:0] {IDLE_R = 2'b00, WRITE = 2'b01, READ = 2'b10, FETCH = 2'b11} rwi_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_WORD_ALT = 2'b11} size_t;
  typedef enum logic [1:0] {IDLE, REQ, FAULT, DONE} mmio_state_t;
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/t07_lane_align.sv
// t07_lane_align: combinational byte-lane steering for the MMIO adapter.
//   size       effective access size (fetch already folded to word)
//   lo         addr[1:0]
//   wdata      right-justified store data
//   bus_rdata  raw Wishbone read data
//   sel        byte-lane selects
//   wdat       lane-shifted store data
//   rdata      right-justified, zero-extended load data
//   misaligned access does not fit its natural alignment
module t07_lane_align
  import t07_mmio_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [31:0] sh;
  assign sh = bus_rdata >> {lo, 3'b000};
  assign wdat = wdata << {lo, 3'b000};
  assign sel = size == SZ_BYTE ? 4'b0001 << lo : size == SZ_HALF ? 4'b0011 << lo : 4'b1111;
  assign rdata = size == SZ_BYTE ? {24'b0, sh[7:0]} : size == SZ_HALF ? {16'b0, sh[15:0]} : sh;
  assign misaligned = size == SZ_BYTE ? 1'b0 : size == SZ_HALF ? lo[0] : |lo;
endmodule

// File: rtl/t07_mmio_wb_adapter.sv
// t07_mmio_wb_adapter: runs one Wishbone-classic cycle per CPU memory-handler request.
//   clk, rst                  clock, async active-high reset
//   rwi_i, size_i, addr_i, wdata_i   handler request
//   busy_o, rdata_o, err_o    handler status / load data / failure pulse
//   wb_*                      Wishbone-classic master port
// Optional: define T07_MMIO_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES cycles.
module t07_mmio_wb_adapter
  import t07_mmio_pkg::*;
#(
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rwi_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  mmio_state_t state;
  logic        armed;
  rwi_t        rwi_q;
  size_t       size_q;
  logic [1:0]  lo_q;
  size_t       size_eff;
  size_t       ln_size;
  logic [1:0]  ln_lo;
  logic [3:0]  ln_sel;
  logic [31:0] ln_wdat;
  logic [31:0] ln_rdata;
  logic        ln_mis;
  logic        abort;
  // Fetches and the reserved size code both behave as word accesses.
  assign size_eff = (rwi_i == FETCH || size_i == 2'b11) ? SZ_WORD : size_t'(size_i);
  // In IDLE the lanes are computed from the live request; afterwards from the captured one.
  assign ln_size = state == IDLE ? size_eff : size_q;
  assign ln_lo = state == IDLE ? addr_i[1:0] : lo_q;
  t07_lane_align u_lane (
    .size(ln_size),
    .lo(ln_lo),
    .wdata(wdata_i),
    .bus_rdata(wb_dat_i),
    .sel(ln_sel),
    .wdat(ln_wdat),
    .rdata(ln_rdata),
    .misaligned(ln_mis)
  );
`ifdef T07_MMIO_TIMEOUT_EN
  logic [9:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= state == REQ ? cnt + 10'd1 : '0;
  end
  assign abort = wb_err_i | (state == REQ && cnt == 10'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^10'(TIMEOUT_CYCLES);
  assign abort = wb_err_i;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      armed    <= 1'b1;
      rwi_q    <= IDLE_R;
      size_q   <= SZ_BYTE;
      lo_q     <= 2'b00;
      busy_o   <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: if (rwi_i != IDLE_R && armed) begin
          rwi_q  <= rwi_t'(rwi_i);
          size_q <= size_eff;
          lo_q   <= addr_i[1:0];
          busy_o <= 1'b1;
          if (ln_mis) state <= FAULT;
          else begin
            state    <= REQ;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= rwi_i == WRITE;
            wb_adr_o <= {addr_i[31:2], 2'b00};
            wb_sel_o <= ln_sel;
            wb_dat_o <= ln_wdat;
          end
        end
        REQ: if (abort || wb_ack_i) begin
          state    <= DONE;
          armed    <= 1'b0;
          busy_o   <= 1'b0;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o  <= 1'b0;
          err_o    <= abort;
          if (rwi_q != WRITE) rdata_o <= abort ? ERR_RDATA : ln_rdata;
        end
        FAULT: begin
          state  <= DONE;
          armed  <= 1'b0;
          busy_o <= 1'b0;
          err_o  <= 1'b1;
          if (rwi_q != WRITE) rdata_o <= ERR_RDATA;
        end
        DONE: if (rwi_i == IDLE_R) begin
          state <= IDLE;
          armed <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_t07_mmio_wb_adapter.sv
// tb_t07_mmio_wb_adapter: table-driven self-checking bench for t07_mmio_wb_adapter.
module tb_t07_mmio_wb_adapter;
`ifdef T07_MMIO_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  logic clk = 0, rst = 1;
  logic [1:0] rwi_i = 0, size_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, wb_dat_i = 0;
  logic wb_ack_i = 0, wb_err_i = 0;
  logic busy_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rdata_o, wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  int n_cmp = 0, n_bad = 0;
  t07_mmio_wb_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rwi_i(rwi_i), .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .rdata_o(rdata_o), .err_o(err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] rwi, size;
    logic [31:0] addr, wdata, bdat;
    int ack_at;
    logic back, berr;
    logic cyc;
    logic [31:0] adr, dato;
    logic [3:0] sel;
    logic we;
    int busy;
    logic [31:0] rdata;
    logic err;
  } vec_t;
  vec_t vecs[12];
  function automatic vec_t mk(logic [1:0] rwi, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] bdat, int ack_at, logic back, logic berr, logic cyc,
                              logic [31:0] adr, logic [3:0] sel, logic [31:0] dato, logic we, int busy,
                              logic [31:0] rdata, logic err);
    vec_t v;
    v.rwi = rwi; v.size = size; v.addr = addr; v.wdata = wdata; v.bdat = bdat;
    v.ack_at = ack_at; v.back = back; v.berr = berr; v.cyc = cyc; v.adr = adr;
    v.sel = sel; v.dato = dato; v.we = we; v.busy = busy; v.rdata = rdata; v.err = err;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic run(input int i);
    vec_t v;
    int bc, cc, n;
    v = vecs[i];
    rwi_i = v.rwi; size_i = v.size; addr_i = v.addr; wdata_i = v.wdata; wb_dat_i = v.bdat;
    wb_ack_i = 0; wb_err_i = 0;
    bc = 0; cc = 0; n = 0;
    @(negedge clk);
    while (busy_o && n < 64) begin
      wb_ack_i = 0; wb_err_i = 0;
      bc++;
      if (wb_cyc_o) begin
        cc++;
        if (cc == 1) begin
          chk($sformatf("v%0d_adr", i), wb_adr_o, v.adr);
          chk($sformatf("v%0d_sel", i), 32'(wb_sel_o), 32'(v.sel));
          chk($sformatf("v%0d_dato", i), wb_dat_o, v.dato);
          chk($sformatf("v%0d_we_stb", i), {30'b0, wb_we_o, wb_stb_o}, {30'b0, v.we, 1'b1});
        end
        if (cc == v.ack_at) begin
          wb_ack_i = v.back; wb_err_i = v.berr;
        end
      end
      @(negedge clk);
      n++;
    end
    wb_ack_i = 0; wb_err_i = 0;
    chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(v.busy));
    chk($sformatf("v%0d_cyc_seen", i), 32'(cc != 0), 32'(v.cyc));
    chk($sformatf("v%0d_rdata", i), rdata_o, v.rdata);
    chk($sformatf("v%0d_err", i), 32'(err_o), 32'(v.err));
    chk($sformatf("v%0d_cyc_end", i), 32'(wb_cyc_o), 0);
    @(negedge clk);
    chk($sformatf("v%0d_err_pulse", i), 32'(err_o), 0);
    chk($sformatf("v%0d_no_reissue", i), {30'b0, busy_o, wb_cyc_o}, 0);
    rwi_i = 0;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0]  = mk(2'b11, 2'b00, 32'h1000, 32'h12345678, 32'h00510513, 4, 1, 0, 1, 32'h1000, 4'b1111, 32'h12345678, 0, 4, 32'h00510513, 0);
    vecs[1]  = mk(2'b01, 2'b00, 32'h2003, 32'h000000AB, 32'h0, 1, 1, 0, 1, 32'h2000, 4'b1000, 32'hAB000000, 1, 1, 32'h00510513, 0);
    vecs[2]  = mk(2'b10, 2'b01, 32'h2002, 32'h0, 32'hBEEF1234, 2, 1, 0, 1, 32'h2000, 4'b1100, 32'h0, 0, 2, 32'h0000BEEF, 0);
    vecs[3]  = mk(2'b10, 2'b01, 32'h2001, 32'h0, 32'hBEEF1234, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 1, 32'hDEADBEEF, 1);
    vecs[4]  = mk(2'b10, 2'b00, 32'h3001, 32'h0, 32'h11223344, 1, 1, 1, 1, 32'h3000, 4'b0010, 32'h0, 0, 1, 32'hDEADBEEF, 1);
    vecs[5]  = mk(2'b10, 2'b00, 32'h4001, 32'h0, 32'h11223344, 1, 1, 0, 1, 32'h4000, 4'b0010, 32'h0, 0, 1, 32'h00000033, 0);
    vecs[6]  = mk(2'b01, 2'b10, 32'h5002, 32'h1, 32'h0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 1, 32'h00000033, 1);
    vecs[7]  = mk(2'b10, 2'b11, 32'h6000, 32'h0, 32'hCAFEF00D, 2, 1, 0, 1, 32'h6000, 4'b1111, 32'h0, 0, 2, 32'hCAFEF00D, 0);
    vecs[8]  = mk(2'b01, 2'b01, 32'h7002, 32'hFFFF5AA5, 32'h0, 1, 1, 0, 1, 32'h7000, 4'b1100, 32'h5AA50000, 1, 1, 32'hCAFEF00D, 0);
    vecs[9]  = mk(2'b11, 2'b00, 32'h8002, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 0, 1, 32'hDEADBEEF, 1);
    vecs[10] = mk(2'b01, 2'b10, 32'h0010, 32'h00000055, 32'h0, 1, 1, 0, 1, 32'h0010, 4'b1111, 32'h00000055, 1, 1, 32'h0, 0);
    vecs[11] = mk(2'b10, 2'b10, 32'hA000, 32'h0, 32'h0, 0, 0, 0, 1, 32'hA000, 4'b1111, 32'h0, 0, 8, 32'hDEADBEEF, 1);
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctrl", {28'b0, busy_o, err_o, wb_cyc_o, wb_stb_o}, 0);
    chk("reset_rdata", rdata_o, 0);
    chk("reset_sel", 32'(wb_sel_o), 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) run(i);
    rwi_i = 2'b10; size_i = 2'b10; addr_i = 32'h9000;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_cyc", 32'(wb_cyc_o), 1);
    rst = 1;
    #1;
    chk("async_reset_drop", {29'b0, wb_cyc_o, wb_stb_o, busy_o}, 0);
    rwi_i = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(10);
`ifdef T07_MMIO_TIMEOUT_EN
    run(11);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
